// File: rtl/tm_lif_pkg.sv
// Shared constants and helpers for the time-multiplexed LIF neuron array.
//   DEF_*     : default parameter values for the array
//   sat_add() : unsigned add clamped to 2^width-1 (operands up to 32 bits)
//   refr_w()  : width of a refractory counter able to hold 0..refract
package tm_lif_pkg;

  localparam int DEF_N_NEURONS  = 4;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_LEAK_SHIFT = 1;
  localparam int DEF_REFRACT    = 2;

  // The sum is formed one bit wider than the operands so a carry is seen
  // before the clamp.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

  // A zero-length refractory period still gets a 1-bit counter so the
  // register file never has zero width.
  function automatic int refr_w(input int refract);
    return (refract < 1) ? 1 : $clog2(refract + 1);
  endfunction

endpackage

// File: rtl/lif_slot_update.sv
// Combinational update of one neuron slot: leak, integrate, saturate,
// threshold, refractory handling.
//   state/refr     : current stored membrane state and refractory count
//   inp, thresh    : selected input current and firing threshold
//   state_nxt/refr_nxt : values to write back into the register file
//   fire           : slot spikes this service
module lif_slot_update
  import tm_lif_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRACT    = DEF_REFRACT,
  parameter int RW         = refr_w(DEF_REFRACT)
) (
  input  logic [WIDTH-1:0] state,
  input  logic [RW-1:0]    refr,
  input  logic [WIDTH-1:0] inp,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] state_nxt,
  output logic [RW-1:0]    refr_nxt,
  output logic             fire
);

  logic [WIDTH-1:0] leak_amt;
  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] sum;

  // A shift of 0 would subtract the whole state, so it means "no leak".
  assign leak_amt = (LEAK_SHIFT == 0) ? '0 : (state >> LEAK_SHIFT);
  assign leaked   = state - leak_amt;
  assign sum      = WIDTH'(sat_add(32'(leaked), 32'(inp), WIDTH));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt = sum;
    refr_nxt  = refr;
    fire      = 1'b0;
    if (refr != '0) begin
      // Refractory: clamp to rest and drop the input entirely.
      state_nxt = '0;
      refr_nxt  = refr - RW'(1);
    end else if (sum >= thresh) begin
      fire      = 1'b1;
      state_nxt = '0;
      refr_nxt  = RW'(REFRACT);
    end
  end

endmodule

// File: rtl/tm_lif_array.sv
// Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons.
// One shared datapath services one slot per enabled clock, round-robin.
//   en          : advance and update the current slot
//   chain       : 1 = slot i>0 integrates the stored state of slot i-1
//   cur_in      : input current for the slot being serviced
//   thresh      : firing threshold
//   cur_idx     : slot serviced this cycle
//   spike_valid/spike/spike_id/state_out : registered result of last slot
//   frame_done  : pulses with the result of the final slot of a frame
//   spike_vec   : spike flags of the last completed frame
module tm_lif_array
  import tm_lif_pkg::*;
#(
  parameter  int N_NEURONS  = DEF_N_NEURONS,
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter  int REFRACT    = DEF_REFRACT,
  localparam int IDX_W      = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 chain,
  input  logic [WIDTH-1:0]     cur_in,
  input  logic [WIDTH-1:0]     thresh,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 spike_valid,
  output logic                 spike,
  output logic [IDX_W-1:0]     spike_id,
  output logic [WIDTH-1:0]     state_out,
  output logic                 frame_done,
  output logic [N_NEURONS-1:0] spike_vec
);

  localparam int              RW   = refr_w(REFRACT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

  logic [IDX_W-1:0]     idx;
  logic [WIDTH-1:0]     state_q [N_NEURONS];
  logic [RW-1:0]        refr_q  [N_NEURONS];
  logic [N_NEURONS-1:0] shadow_q;

  logic [WIDTH-1:0]     slot_in;
  logic [WIDTH-1:0]     state_nxt;
  logic [RW-1:0]        refr_nxt;
  logic                 fire;
  logic [N_NEURONS-1:0] flags_nxt;

  assign cur_idx = idx;

  // Chained mode reads the predecessor's stored state, which was written
  // at the end of the previous cycle, i.e. already updated this frame.
  always_comb begin
    slot_in = cur_in;
    if (chain && (idx != '0)) slot_in = state_q[idx - IDX_W'(1)];
  end

  lif_slot_update #(
    .WIDTH     (WIDTH),
    .LEAK_SHIFT(LEAK_SHIFT),
    .REFRACT   (REFRACT),
    .RW        (RW)
  ) u_update (
    .state    (state_q[idx]),
    .refr     (refr_q[idx]),
    .inp      (slot_in),
    .thresh   (thresh),
    .state_nxt(state_nxt),
    .refr_nxt (refr_nxt),
    .fire     (fire)
  );

  // Frame flags including the slot being serviced now, so the last slot's
  // spike lands in spike_vec together with frame_done.
  always_comb begin
    flags_nxt      = shadow_q;
    flags_nxt[idx] = fire;
  end

  // NOTE: sequential state uses non-blocking assignments only; the register
  // file is reset too because a reset must restart every neuron from rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      shadow_q    <= '0;
      spike_valid <= 1'b0;
      spike       <= 1'b0;
      spike_id    <= '0;
      state_out   <= '0;
      frame_done  <= 1'b0;
      spike_vec   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        refr_q[i]  <= '0;
      end
    end else if (en) begin
      state_q[idx] <= state_nxt;
      refr_q[idx]  <= refr_nxt;
      spike_valid  <= 1'b1;
      spike        <= fire;
      spike_id     <= idx;
      state_out    <= state_nxt;
      if (idx == LAST) begin
        idx        <= '0;
        spike_vec  <= flags_nxt;
        shadow_q   <= '0;
        frame_done <= 1'b1;
      end else begin
        idx        <= idx + IDX_W'(1);
        shadow_q   <= flags_nxt;
        frame_done <= 1'b0;
      end
    end else begin
      spike_valid <= 1'b0;
      frame_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tm_lif_array.sv
// Self-checking bench for tm_lif_array (N=4, WIDTH=8, LEAK_SHIFT=1,
// REFRACT=2). A behavioural model predicts each slot result into a queue;
// a monitor pops and compares whenever spike_valid is seen.
module tb_tm_lif_array;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LS = 1;
  localparam int RF = 2;
  localparam int MAXV = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       chain = 1'b0;
  logic [7:0] cur_in = '0;
  logic [7:0] thresh = '0;
  logic [1:0] cur_idx;
  logic       spike_valid;
  logic       spike;
  logic [1:0] spike_id;
  logic [7:0] state_out;
  logic       frame_done;
  logic [3:0] spike_vec;

  always #5 clk = ~clk;

  tm_lif_array #(
    .N_NEURONS (N),
    .WIDTH     (W),
    .LEAK_SHIFT(LS),
    .REFRACT   (RF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .chain      (chain),
    .cur_in     (cur_in),
    .thresh     (thresh),
    .cur_idx    (cur_idx),
    .spike_valid(spike_valid),
    .spike      (spike),
    .spike_id   (spike_id),
    .state_out  (state_out),
    .frame_done (frame_done),
    .spike_vec  (spike_vec)
  );

  typedef struct {
    int spike;
    int id;
    int st;
    int fd;
    int vec;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   hold_vec = 0;

  // Reference model: plain integer membrane values and refractory counts.
  int m_st[N];
  int m_rf[N];
  int m_sh;
  int m_vec;
  int m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0;
      m_rf[i] = 0;
    end
    m_sh  = 0;
    m_vec = 0;
    m_idx = 0;
  endtask

  task automatic model_step(input int cur, input int thr, input bit ch, output res_t r);
    int inp;
    int sum;
    bit fire;
    inp  = (ch && m_idx > 0) ? m_st[m_idx-1] : cur;
    fire = 1'b0;
    if (m_rf[m_idx] > 0) begin
      m_st[m_idx] = 0;
      m_rf[m_idx] = m_rf[m_idx] - 1;
    end else begin
      sum = m_st[m_idx] - (m_st[m_idx] >> LS) + inp;
      if (sum > MAXV) sum = MAXV;
      if (sum >= thr) begin
        fire        = 1'b1;
        m_st[m_idx] = 0;
        m_rf[m_idx] = RF;
      end else begin
        m_st[m_idx] = sum;
      end
    end
    if (fire) m_sh = m_sh | (1 << m_idx);
    r.spike = int'(fire);
    r.id    = m_idx;
    r.st    = m_st[m_idx];
    r.fd    = 0;
    r.vec   = m_vec;
    if (m_idx == N - 1) begin
      m_vec = m_sh;
      m_sh  = 0;
      r.fd  = 1;
      r.vec = m_vec;
    end
    m_idx = (m_idx + 1) % N;
  endtask

  // One clock of stimulus, driven on the falling edge.
  task automatic cycle(input bit e, input int cur, input int thr, input bit ch);
    res_t r;
    @(negedge clk);
    check("cur_idx", 32'(cur_idx), m_idx);
    en     = e;
    cur_in = cur[7:0];
    thresh = thr[7:0];
    chain  = ch;
    if (e) begin
      model_step(cur, thr, ch, r);
      exp_q.push_back(r);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("rst_cur_idx",     32'(cur_idx), 0);
    check("rst_spike_valid", 32'(spike_valid), 0);
    check("rst_spike",       32'(spike), 0);
    check("rst_spike_id",    32'(spike_id), 0);
    check("rst_state_out",   32'(state_out), 0);
    check("rst_frame_done",  32'(frame_done), 0);
    check("rst_spike_vec",   32'(spike_vec), 0);
    check("rst_queue_empty", exp_q.size(), 0);
    model_reset();
    hold_vec = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented result against the scoreboard.
  initial begin
    res_t r;
    res_t o;
    forever begin
      @(posedge clk);
      #1;
      if (spike_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got id %0d with no prediction", spike_id);
        end else begin
          r = exp_q.pop_front();
          check("spike",      32'(spike), r.spike);
          check("spike_id",   32'(spike_id), r.id);
          check("state_out",  32'(state_out), r.st);
          check("frame_done", 32'(frame_done), r.fd);
          check("spike_vec",  32'(spike_vec), r.vec);
          hold_vec = r.vec;
          o.spike = int'(spike);
          o.id    = int'(spike_id);
          o.st    = int'(state_out);
          o.fd    = int'(frame_done);
          o.vec   = int'(spike_vec);
          obs_q.push_back(o);
        end
      end else begin
        check("idle_frame_done", 32'(frame_done), 0);
        check("idle_spike_vec",  32'(spike_vec), hold_vec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Collect the observed results of one neuron, in order.
  task automatic neuron_obs(input int id, output int sp[$], output int st[$]);
    sp = {};
    st = {};
    foreach (obs_q[k]) begin
      if (obs_q[k].id == id) begin
        sp.push_back(obs_q[k].spike);
        st.push_back(obs_q[k].st);
      end
    end
  endtask

  initial begin
    int sp[$];
    int st[$];
    int exp_int[8];
    int first_vec;
    int c;
    int t;
    bit ch;

    model_reset();
    repeat (3) @(negedge clk);
    check("init_spike_valid", 32'(spike_valid), 0);
    check("init_state_out",   32'(state_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Integrate: neuron 0 climbs toward the threshold and fires in frame 8.
    obs_q.delete();
    repeat (32) cycle(1'b1, 100, 200, 1'b0);
    cycle(1'b0, 0, 200, 1'b0);
    exp_int = '{100, 150, 175, 188, 194, 197, 199, 0};
    neuron_obs(0, sp, st);
    check("integ_count", sp.size(), 8);
    for (int i = 0; i < 8 && i < sp.size(); i++) begin
      check($sformatf("integ_state_f%0d", i + 1), st[i], exp_int[i]);
      check($sformatf("integ_spike_f%0d", i + 1), sp[i], (i == 7) ? 1 : 0);
    end

    // Refractory: fire, two silent frames, fire again.
    do_reset();
    obs_q.delete();
    repeat (16) cycle(1'b1, 255, 200, 1'b0);
    cycle(1'b0, 0, 200, 1'b0);
    neuron_obs(0, sp, st);
    check("refr_count", sp.size(), 4);
    for (int i = 0; i < 4 && i < sp.size(); i++) begin
      check($sformatf("refr_spike_f%0d", i + 1), sp[i], (i == 0 || i == 3) ? 1 : 0);
      check($sformatf("refr_state_f%0d", i + 1), st[i], 0);
    end
    first_vec = -1;
    foreach (obs_q[k]) if (obs_q[k].fd == 1 && first_vec < 0) first_vec = obs_q[k].vec;
    check("refr_first_vec", first_vec, 15);

    // Saturation: 100 + 200 clamps to 255, which meets a threshold of 255.
    do_reset();
    obs_q.delete();
    repeat (8) cycle(1'b1, 200, 255, 1'b0);
    cycle(1'b0, 0, 255, 1'b0);
    neuron_obs(0, sp, st);
    check("sat_count", sp.size(), 2);
    if (sp.size() == 2) begin
      check("sat_state_f1", st[0], 200);
      check("sat_spike_f1", sp[0], 0);
      check("sat_state_f2", st[1], 0);
      check("sat_spike_f2", sp[1], 1);
    end

    // Chain: neuron 0 fires, so neuron 1 receives its reset state of 0.
    do_reset();
    obs_q.delete();
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < N; s++) cycle(1'b1, (s == 0) ? 255 : 0, 250, 1'b1);
    cycle(1'b0, 0, 250, 1'b1);
    neuron_obs(0, sp, st);
    if (sp.size() > 0) begin
      check("chain_n0_spike_f1", sp[0], 1);
      check("chain_n0_state_f1", st[0], 0);
    end else check("chain_n0_present", 0, 1);
    neuron_obs(1, sp, st);
    if (sp.size() > 0) begin
      check("chain_n1_spike_f1", sp[0], 0);
      check("chain_n1_state_f1", st[0], 0);
    end else check("chain_n1_present", 0, 1);

    // Chain with a sub-threshold head: cur_in on later slots is ignored.
    do_reset();
    obs_q.delete();
    for (int s = 0; s < N; s++) cycle(1'b1, (s == 0) ? 100 : 7, 250, 1'b1);
    cycle(1'b0, 0, 250, 1'b1);
    neuron_obs(1, sp, st);
    if (sp.size() > 0) check("chain_n1_follows", st[0], 100);
    else check("chain_n1_present2", 0, 1);

    // Enable gating: hold at slot 1 for five cycles, then resume.
    do_reset();
    cycle(1'b1, 90, 230, 1'b0);
    repeat (5) cycle(1'b0, 255, 0, 1'b0);
    repeat (7) cycle(1'b1, 90, 230, 1'b0);
    cycle(1'b0, 0, 230, 1'b0);

    // Randomised traffic, including chain toggles and zero thresholds.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      t  = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) t = 0;
      c  = $urandom_range(0, 255);
      ch = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 4) != 0), c, t, ch);
    end
    cycle(1'b0, 0, 0, 1'b0);

    // Reset asserted mid-frame at slot 2; states restart from zero.
    do_reset();
    while (m_idx != 2) cycle(1'b1, 100, 200, 1'b0);
    cycle(1'b1, 100, 200, 1'b0);
    do_reset();
    obs_q.delete();
    repeat (N) cycle(1'b1, 100, 200, 1'b0);
    cycle(1'b0, 0, 200, 1'b0);
    neuron_obs(2, sp, st);
    if (sp.size() > 0) check("midrst_n2_restart", st[0], 100);
    else check("midrst_n2_present", 0, 1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
